// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   - HEX_PATTERN : active-low g..a patterns for hex digits 0..F
//   - SEG_DP_BIT  : position of the decimal point in the 8-bit segment bus
//   - SEG_BLANK   : segment bus value with every segment (and DP) dark
//   - SEG_PATTERN_OFF : 7-bit pattern with all of g..a dark
// No ports (package).
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_pattern_t;

    localparam int           SEG_DP_BIT      = 7;
    localparam logic [7:0]   SEG_BLANK       = 8'hFF;
    localparam seg_pattern_t SEG_PATTERN_OFF = 7'h7F;

    // Segment order g..a in bits 6..0, a lit segment is 0.
    localparam seg_pattern_t HEX_PATTERN [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
        7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
    };

    function automatic seg_pattern_t hex_to_pattern(input nibble_t nib);
        return HEX_PATTERN[nib];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// ----------------------------------------------------------------------------
// seg7_hex_decode
// Purely combinational hex nibble to seven-segment pattern decoder.
// Ports:
//   nibble  (in,  4) : hex value 0..F
//   pattern (out, 7) : active-low segments g..a
// ----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = hex_to_pattern(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for N_DIGITS common-anode seven-segment digits.
// Each digit owns a slot of DIV clock cycles; the first BLANK cycles of every
// slot keep all digits dark to avoid ghosting while the digit select moves.
// New values are captured into a pending register on load and only promoted
// to the display register at the frame boundary, so a frame never mixes two
// values.
//
// Ports:
//   clk        (in,  1)          : clock, rising edge
//   rst        (in,  1)          : synchronous active-high reset
//   data_in    (in,  4*N_DIGITS) : hex nibbles, digit 0 at [3:0]
//   dp_mask    (in,  N_DIGITS)   : decimal-point enables, bit k = digit k
//   load       (in,  1)          : capture strobe for data_in / dp_mask
//   seg        (out, 8)          : active-low segments, bit7 = DP, 6:0 = g..a
//   dig_sel    (out, N_DIGITS)   : active-low one-hot digit enable
//   frame_done (out, 1)          : high during the frame-boundary cycle
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, digits above the most
//   significant nonzero nibble are blanked (digit 0 always shown, DP kept).
// ----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 8,
    parameter int DIV      = 50000,
    parameter int BLANK    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_mask,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [N_DIGITS-1:0]   dig_sel,
    output logic                  frame_done
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      div_cnt;
    logic [IDX_W-1:0]      idx;
    logic                  slot_end;
    logic                  frame_bnd;

    logic [4*N_DIGITS-1:0] pend_data;
    logic [N_DIGITS-1:0]   pend_dp;
    logic [4*N_DIGITS-1:0] disp_data;
    logic [N_DIGITS-1:0]   disp_dp;

    logic [N_DIGITS-1:0]   lz_mask;
    logic [3:0]            cur_nibble;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [6:0]            dec_pattern;
    logic                  active;

    logic [7:0]            seg_p0;
    logic [N_DIGITS-1:0]   dig_sel_p0;
    logic                  frame_done_p0;

    logic [7:0]            seg_p1;
    logic [N_DIGITS-1:0]   dig_sel_p1;
    logic                  frame_done_p1;

    // ---- stage p0: scan counters and value registers ----
    assign slot_end  = (div_cnt == CNT_LAST);
    assign frame_bnd = slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // A load on the boundary cycle goes straight to the display register so
    // it is not delayed by a whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else begin
            if (load) begin
                pend_data <= data_in;
                pend_dp   <= dp_mask;
            end
            if (frame_bnd) begin
                disp_data <= load ? data_in : pend_data;
                disp_dp   <= load ? dp_mask : pend_dp;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; a digit is blanked while every nibble
    // from it upward is zero. Digit 0 is excluded so "0" still shows.
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run   = zero_run && (disp_data[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end
`else
    assign lz_mask = '0;
`endif

    always_comb begin
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_nibble = disp_data[4*k +: 4];
                cur_dp     = disp_dp[k];
                cur_lz     = lz_mask[k];
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble  (cur_nibble),
        .pattern (dec_pattern)
    );

    assign active = (div_cnt >= CNT_BLANK);

    always_comb begin
        seg_p0     = SEG_BLANK;
        dig_sel_p0 = '1;
        if (active) begin
            seg_p0[SEG_DP_BIT] = ~cur_dp;
            seg_p0[6:0]        = cur_lz ? SEG_PATTERN_OFF : dec_pattern;
            for (int k = 0; k < N_DIGITS; k++) begin
                dig_sel_p0[k] = (idx != IDX_W'(k));
            end
        end
    end

    // frame_done is registered one cycle early so it is high exactly during
    // the boundary cycle itself. DIV >= 2 guarantees idx is already at its
    // last value when div_cnt reaches DIV-2.
    assign frame_done_p0 = (div_cnt == CNT_PRE) && (idx == IDX_LAST);

    // ---- stage p1: registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1        <= SEG_BLANK;
            dig_sel_p1    <= '1;
            frame_done_p1 <= 1'b0;
        end else begin
            seg_p1        <= seg_p0;
            dig_sel_p1    <= dig_sel_p0;
            frame_done_p1 <= frame_done_p0;
        end
    end

    assign seg        = seg_p1;
    assign dig_sel    = dig_sel_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Scoreboard bench for seg7_scan_driver with N_DIGITS=8, DIV=4, BLANK=1.
// The stimulus process keeps a cycle-indexed reference model (time since
// reset, pending/display values) and pushes the expected outputs of the
// following cycle into a queue; a monitor pops and compares every cycle.
// Honours SEG7_LEADING_ZERO_BLANK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N     = 8;
    localparam int DV    = 4;
    localparam int BL    = 1;
    localparam int FRAME = N * DV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  dp_mask;
    logic [7:0]  seg;
    logic [7:0]  dig_sel;
    logic        frame_done;

    seg7_scan_driver #(
        .N_DIGITS (N),
        .DIV      (DV),
        .BLANK    (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .dp_mask    (dp_mask),
        .load       (load),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] seg;
        logic [7:0] dig;
        logic       fd;
    } exp_t;

    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference hex table with the DP off (bit7 = 1).
    logic [7:0] HEX_REF [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Reference model state: t is the index of the cycle being set up,
    // counted from the first cycle after the last reset edge.
    int          t = 0;
    logic [31:0] pend_d = '0;
    logic [7:0]  pend_m = '0;
    logic [31:0] disp_d = '0;
    logic [7:0]  disp_m = '0;

    function automatic logic [7:0] ref_digit(input int k);
        logic [7:0] p;
        p = HEX_REF[disp_d[4*k +: 4]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int j = 0; j < N; j++) if (disp_d[4*j +: 4] != 4'h0) msd = j;
            if (k > msd) p = 8'hFF;
        end
`endif
        return disp_m[k] ? (p & 8'h7F) : p;
    endfunction

    task automatic step(input bit r, input bit ld, input logic [31:0] d, input logic [7:0] m);
        exp_t e;
        int   ph;
        int   dg;
        @(posedge clk);
        #1;
        rst     = r;
        load    = ld;
        data_in = d;
        dp_mask = m;
        e.cyc   = cyc + 1;
        if (r) begin
            e.seg  = 8'hFF;
            e.dig  = 8'hFF;
            e.fd   = 1'b0;
            pend_d = '0;
            pend_m = '0;
            disp_d = '0;
            disp_m = '0;
            t      = 0;
        end else begin
            ph = t % DV;
            dg = (t / DV) % N;
            if (ph < BL) begin
                e.seg = 8'hFF;
                e.dig = 8'hFF;
            end else begin
                e.seg = ref_digit(dg);
                e.dig = ~(8'h01 << dg);
            end
            e.fd = (((t + 1) % FRAME) == FRAME - 1);
            if ((t % FRAME) == FRAME - 1) begin
                disp_d = ld ? d : pend_d;
                disp_m = ld ? m : pend_m;
            end
            if (ld) begin
                pend_d = d;
                pend_m = m;
            end
            t++;
        end
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 8'($urandom));
    endtask

    task automatic go_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) idle(1);
    endtask

    function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
        end
    endfunction

    // Monitor: compare the outputs of every cycle that has an expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL stale expectation for cycle %0d seen at cycle %0d", e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("seg", seg, e.seg);
                check("dig_sel", dig_sel, e.dig);
                check("frame_done", {7'b0, frame_done}, {7'b0, e.fd});
                n_cmp++;
                if ($countones(~dig_sel) > 1) begin
                    n_bad++;
                    $display("FAIL dig_sel_onehot at cycle %0d: got %h, required at most one low bit", cyc, dig_sel);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        data_in = '0;
        dp_mask = '0;

        // Reset held over two edges, then free-run past two frame boundaries.
        step(1'b1, 1'b0, 32'h0, 8'h0);
        idle(70);

        // Plain hex display.
        go_to(10);
        step(1'b0, 1'b1, 32'h12345678, 8'h00);
        idle(2 * FRAME);

        // Decimal point.
        go_to(5);
        step(1'b0, 1'b1, 32'h000000A0, 8'h04);
        idle(2 * FRAME);

        // Load on the boundary cycle bypasses; a load one cycle later waits.
        go_to(FRAME - 1);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 8'h00);
        step(1'b0, 1'b1, 32'h00000001, 8'h00);
        idle(2 * FRAME + 4);

        // Leading zeros.
        go_to(12);
        step(1'b0, 1'b1, 32'h00000050, 8'h00);
        idle(2 * FRAME);

        // Reset in digit 5 together with a load.
        go_to(21);
        step(1'b1, 1'b1, 32'hDEADBEEF, 8'hFF);
        idle(40);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 900; i++) begin
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
                 $urandom, 8'($urandom));
        end
        idle(FRAME);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
